// File: rtl/tdm_demux_1_4_if.sv
// Link-side bundle for the 1:4 TDM demultiplexer: serial beat inputs plus
// the assembled-frame and framing-status outputs.
interface tdm_demux_1_4_if #(
   parameter int W = 8
);
   logic [W-1:0]   din;
   logic           din_valid;
   logic           sof;
   logic [4*W-1:0] dout;
   logic           dout_valid;
   logic [3:0]     slot_en;
   logic           locked;
   logic           frame_err;

   modport master (
      output din, din_valid, sof,
      input  dout, dout_valid, slot_en, locked, frame_err
   );

   modport slave (
      input  din, din_valid, sof,
      output dout, dout_valid, slot_en, locked, frame_err
   );
endinterface

// File: rtl/tdm_demux_1_4.sv
// 1:4 TDM demultiplexer: steers four slot beats into lane registers via a
// one-hot slot decoder and emits each completed frame as one parallel word.
module tdm_demux_1_4 #(
   parameter int W = 8
) (
   input logic              clk,
   input logic              rst,
   tdm_demux_1_4_if.slave   link
);

   typedef enum logic {
      HUNT = 1'b0,
      LOCK = 1'b1
   } state_t;

   state_t         state_q, state_d;
   logic [1:0]     cnt_q, cnt_d;
   logic [W-1:0]   lane_q [3];
   logic [2:0]     lane_we_s;
   logic [4*W-1:0] dout_q, dout_d;
   logic           dout_valid_q, dout_valid_d;
   logic           frame_err_q, frame_err_d;
   logic           locked_q;
   logic [3:0]     slot_en_s;

   // Expected-slot decoder; silent while hunting for a start of frame.
   always_comb begin
      if (state_q == LOCK) begin
         slot_en_s = 4'b0001 << cnt_q;
      end else begin
         slot_en_s = 4'b0000;
      end
   end

   // Next-state, lane write enables and frame/error outputs.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      lane_we_s    = 3'b000;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      frame_err_d  = 1'b0;
      if (link.din_valid) begin
         case (state_q)
            HUNT: begin
               if (link.sof) begin
                  lane_we_s = 3'b001;
                  cnt_d     = 2'd1;
                  state_d   = LOCK;
               end else begin
                  state_d = HUNT;
               end
            end
            LOCK: begin
               if (link.sof) begin
                  // An early sof abandons the partial frame and restarts at slot 0.
                  frame_err_d = (cnt_q != 2'd0);
                  lane_we_s   = 3'b001;
                  cnt_d       = 2'd1;
               end else begin
                  case (cnt_q)
                     2'd0: begin
                        frame_err_d = 1'b1;
                        state_d     = HUNT;
                        cnt_d       = 2'd0;
                     end
                     2'd3: begin
                        dout_d       = {link.din, lane_q[2], lane_q[1], lane_q[0]};
                        dout_valid_d = 1'b1;
                        cnt_d        = 2'd0;
                     end
                     default: begin
                        lane_we_s = slot_en_s[2:0];
                        cnt_d     = cnt_q + 2'd1;
                     end
                  endcase
               end
            end
            default: begin
               state_d = HUNT;
               cnt_d   = 2'd0;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Control and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= HUNT;
         cnt_q        <= 2'd0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         locked_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         frame_err_q  <= frame_err_d;
         locked_q     <= (state_d == LOCK);
      end
   end

   // Lane registers, each written only by its own decoded enable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            lane_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (lane_we_s[i]) begin
               lane_q[i] <= link.din;
            end
         end
      end
   end

   assign link.dout       = dout_q;
   assign link.dout_valid = dout_valid_q;
   assign link.frame_err  = frame_err_q;
   assign link.locked     = locked_q;
   assign link.slot_en    = slot_en_s;

endmodule

// File: tb/tb_tdm_demux_1_4.sv
// Directed self-checking bench for tdm_demux_1_4: inputs change on the falling
// edge, outputs are checked on the falling edge after each rising edge.
module tb_tdm_demux_1_4;

   logic clk;
   logic rst;
   int   n_assert;
   int   n_fail;

   tdm_demux_1_4_if #(.W(8)) bus ();

   tdm_demux_1_4 #(.W(8)) dut (
      .clk  (clk),
      .rst  (rst),
      .link (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of input (valid, sof, data) and advance to the next falling edge.
   task automatic cyc(input logic v, input logic s, input logic [7:0] d);
      bus.din_valid = v;
      bus.sof       = s;
      bus.din       = d;
      @(negedge clk);
      bus.din_valid = 1'b0;
      bus.sof       = 1'b0;
   endtask

   task automatic chk_out(input string tag, input logic [31:0] dout, input logic dv,
                          input logic [3:0] en, input logic lk, input logic err);
      chk({tag, "_dout"}, bus.dout, dout);
      chk({tag, "_dv"},   {31'd0, bus.dout_valid}, {31'd0, dv});
      chk({tag, "_en"},   {28'd0, bus.slot_en}, {28'd0, en});
      chk({tag, "_lk"},   {31'd0, bus.locked}, {31'd0, lk});
      chk({tag, "_err"},  {31'd0, bus.frame_err}, {31'd0, err});
   endtask

   initial begin
      n_assert      = 0;
      n_fail        = 0;
      rst           = 1'b1;
      bus.din       = 8'h00;
      bus.din_valid = 1'b0;
      bus.sof       = 1'b0;
      repeat (2) @(negedge clk);
      chk_out("reset", 32'h0, 1'b0, 4'b0000, 1'b0, 1'b0);
      rst = 1'b0;
      @(negedge clk);

      // Basic frame on consecutive cycles
      cyc(1'b1, 1'b1, 8'hA1); chk_out("f1_a1", 32'h0, 1'b0, 4'b0010, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 8'hB2); chk_out("f1_b2", 32'h0, 1'b0, 4'b0100, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 8'hC3); chk_out("f1_c3", 32'h0, 1'b0, 4'b1000, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 8'hD4); chk_out("f1_d4", 32'hD4C3B2A1, 1'b1, 4'b0001, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 8'h00); chk_out("f1_idle", 32'hD4C3B2A1, 1'b0, 4'b0001, 1'b1, 1'b0);

      // Same frame with 3-cycle gaps; state held during gaps
      cyc(1'b1, 1'b1, 8'hA1);
      repeat (3) begin cyc(1'b0, 1'b1, 8'hEE); chk_out("g_a1", 32'hD4C3B2A1, 1'b0, 4'b0010, 1'b1, 1'b0); end
      cyc(1'b1, 1'b0, 8'hB2);
      repeat (3) begin cyc(1'b0, 1'b0, 8'hEE); chk_out("g_b2", 32'hD4C3B2A1, 1'b0, 4'b0100, 1'b1, 1'b0); end
      cyc(1'b1, 1'b0, 8'hC3);
      repeat (3) begin cyc(1'b0, 1'b1, 8'hEE); chk_out("g_c3", 32'hD4C3B2A1, 1'b0, 4'b1000, 1'b1, 1'b0); end
      cyc(1'b1, 1'b0, 8'hD4); chk_out("g_d4", 32'hD4C3B2A1, 1'b1, 4'b0001, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 8'h00); chk_out("g_idle", 32'hD4C3B2A1, 1'b0, 4'b0001, 1'b1, 1'b0);

      // Back-to-back frames
      cyc(1'b1, 1'b1, 8'h11);
      cyc(1'b1, 1'b0, 8'h22);
      cyc(1'b1, 1'b0, 8'h33); chk_out("bb_33", 32'hD4C3B2A1, 1'b0, 4'b1000, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 8'h44); chk_out("bb_44", 32'h44332211, 1'b1, 4'b0001, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 8'h55); chk_out("bb_55", 32'h44332211, 1'b0, 4'b0010, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 8'h66);
      cyc(1'b1, 1'b0, 8'h77); chk_out("bb_77", 32'h44332211, 1'b0, 4'b1000, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 8'h88); chk_out("bb_88", 32'h88776655, 1'b1, 4'b0001, 1'b1, 1'b0);

      // Early sof discards the partial frame
      cyc(1'b1, 1'b1, 8'hA1);
      cyc(1'b1, 1'b0, 8'hB2); chk_out("es_b2", 32'h88776655, 1'b0, 4'b0100, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 8'hE0); chk_out("es_e0", 32'h88776655, 1'b0, 4'b0010, 1'b1, 1'b1);
      cyc(1'b1, 1'b0, 8'hF1); chk_out("es_f1", 32'h88776655, 1'b0, 4'b0100, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 8'hF2);
      cyc(1'b1, 1'b0, 8'hF3); chk_out("es_f3", 32'hF3F2F1E0, 1'b1, 4'b0001, 1'b1, 1'b0);

      // Missing sof drops lock; non-sof beats ignored until relock
      cyc(1'b1, 1'b0, 8'h55); chk_out("ms_55", 32'hF3F2F1E0, 1'b0, 4'b0000, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 8'h66); chk_out("ms_66", 32'hF3F2F1E0, 1'b0, 4'b0000, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 8'h12); chk_out("ms_12", 32'hF3F2F1E0, 1'b0, 4'b0010, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 8'h34);
      cyc(1'b1, 1'b0, 8'h56);
      cyc(1'b1, 1'b0, 8'h78); chk_out("ms_78", 32'h78563412, 1'b1, 4'b0001, 1'b1, 1'b0);

      // Asynchronous reset mid-frame
      cyc(1'b1, 1'b1, 8'h9A);
      cyc(1'b1, 1'b0, 8'hBC); chk_out("rs_bc", 32'h78563412, 1'b0, 4'b0100, 1'b1, 1'b0);
      rst = 1'b1;
      #1;
      chk_out("rs_async", 32'h0, 1'b0, 4'b0000, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      cyc(1'b1, 1'b0, 8'hFF); chk_out("rs_hunt", 32'h0, 1'b0, 4'b0000, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 8'hC1);
      cyc(1'b1, 1'b0, 8'hC2);
      cyc(1'b1, 1'b0, 8'hC3);
      cyc(1'b1, 1'b0, 8'hC4); chk_out("rs_c4", 32'hC4C3C2C1, 1'b1, 4'b0001, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 8'h00); chk_out("rs_idle", 32'hC4C3C2C1, 1'b0, 4'b0001, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
